// File: rtl/clock_set_ctrl.sv
// HH:MM clock with two-button set; 24-hour by default, 12-hour with pm flag when TWELVE_HOUR_EN is defined.
// Digits and blank are registered, one cycle after a tick or press pulse; buttons have no backpressure.

module clock_set_ctrl_deb #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] CNT_MAX = DW'(DEB_CYCLES - 1);

    logic          sync_a, sync_b, level, level_q;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_a  <= raw;
            sync_b  <= sync_a;
            level_q <= level;
            // any cycle agreeing with the current level restarts the stability window
            if (sync_b != level) begin
                if (cnt == CNT_MAX) begin
                    level <= sync_b;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + DW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_q;
endmodule

module clock_set_ctrl #(
    parameter int CLK_HZ     = 100000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] s_hourten,
    output logic [3:0] s_hour,
    output logic [3:0] s_minten,
    output logic [3:0] s_min,
    output logic [3:0] blank,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       pm
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] HALF      = PW'(CLK_HZ / 2);

`ifdef TWELVE_HOUR_EN
    localparam logic [3:0] RST_HT = 4'd1;
    localparam logic [3:0] RST_H  = 4'd2;
`else
    localparam logic [3:0] RST_HT = 4'd0;
    localparam logic [3:0] RST_H  = 4'd0;
`endif

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_t;

    mode_t         state;
    logic [PW-1:0] presc;
    logic [5:0]    sec;
    logic          mode_press, inc_press, phase;
    logic [3:0]    hr_nxt_ten, hr_nxt_one, min_nxt_ten, min_nxt_one;
    logic          hr_pm_flip, min_wrap;

    clock_set_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(clk), .rst(rst), .raw(btn_mode), .press(mode_press)
    );
    clock_set_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk(clk), .rst(rst), .raw(btn_inc), .press(inc_press)
    );

    assign phase = (presc < HALF);
    assign mode  = state;

    always_comb begin
        hr_nxt_ten = s_hourten;
        hr_nxt_one = s_hour + 4'd1;
        hr_pm_flip = 1'b0;
`ifdef TWELVE_HOUR_EN
        if (s_hourten == 4'd1 && s_hour == 4'd2) begin
            hr_nxt_ten = 4'd0;
            hr_nxt_one = 4'd1;
        end else if (s_hourten == 4'd1 && s_hour == 4'd1) begin
            hr_nxt_ten = 4'd1;
            hr_nxt_one = 4'd2;
            hr_pm_flip = 1'b1;
        end else if (s_hour == 4'd9) begin
            hr_nxt_ten = 4'd1;
            hr_nxt_one = 4'd0;
        end
`else
        if (s_hourten == 4'd2 && s_hour == 4'd3) begin
            hr_nxt_ten = 4'd0;
            hr_nxt_one = 4'd0;
        end else if (s_hour == 4'd9) begin
            hr_nxt_ten = s_hourten + 4'd1;
            hr_nxt_one = 4'd0;
        end
`endif
    end

    always_comb begin
        min_nxt_ten = s_minten;
        min_nxt_one = s_min + 4'd1;
        min_wrap    = 1'b0;
        if (s_minten == 4'd5 && s_min == 4'd9) begin
            min_nxt_ten = 4'd0;
            min_nxt_one = 4'd0;
            min_wrap    = 1'b1;
        end else if (s_min == 4'd9) begin
            min_nxt_ten = s_minten + 4'd1;
            min_nxt_one = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            presc     <= '0;
            sec_tick  <= 1'b0;
            blank     <= 4'b0000;
            sec       <= 6'd0;
            s_hourten <= RST_HT;
            s_hour    <= RST_H;
            s_minten  <= 4'd0;
            s_min     <= 4'd0;
            pm        <= 1'b0;
        end else begin
            presc    <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
            sec_tick <= (presc == PRESC_MAX);

            case (state)
                SET_HR:  blank <= {phase, phase, 2'b00};
                SET_MIN: blank <= {2'b00, phase, phase};
                default: blank <= 4'b0000;
            endcase

            if (mode_press) begin
                case (state)
                    RUN:     state <= SET_HR;
                    SET_HR:  state <= SET_MIN;
                    default: begin
                        state <= RUN;
                        sec   <= 6'd0;
                    end
                endcase
            end

            // an inc press coinciding with a mode press is dropped
            case (state)
                RUN: begin
                    if (sec_tick) begin
                        if (sec == 6'd59) begin
                            sec      <= 6'd0;
                            s_minten <= min_nxt_ten;
                            s_min    <= min_nxt_one;
                            if (min_wrap) begin
                                s_hourten <= hr_nxt_ten;
                                s_hour    <= hr_nxt_one;
                                pm        <= pm ^ hr_pm_flip;
                            end
                        end else begin
                            sec <= sec + 6'd1;
                        end
                    end
                end
                SET_HR: begin
                    if (inc_press && !mode_press) begin
                        s_hourten <= hr_nxt_ten;
                        s_hour    <= hr_nxt_one;
                        pm        <= pm ^ hr_pm_flip;
                    end
                end
                SET_MIN: begin
                    if (inc_press && !mode_press) begin
                        s_minten <= min_nxt_ten;
                        s_min    <= min_nxt_one;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl at CLK_HZ=10, DEB_CYCLES=3; follows TWELVE_HOUR_EN like the design.
module tb_clock_set_ctrl;
`ifdef TWELVE_HOUR_EN
    localparam logic [3:0] RST_HT = 4'd1, RST_H = 4'd2;
    localparam int         N_HR_INC = 11;
    localparam logic [3:0] PRE_HT = 4'd1, PRE_H = 4'd1;
    localparam logic [3:0] END_HT = 4'd1, END_H = 4'd2;
    localparam logic       END_PM = 1'b1;
`else
    localparam logic [3:0] RST_HT = 4'd0, RST_H = 4'd0;
    localparam int         N_HR_INC = 23;
    localparam logic [3:0] PRE_HT = 4'd2, PRE_H = 4'd3;
    localparam logic [3:0] END_HT = 4'd0, END_H = 4'd0;
    localparam logic       END_PM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] s_hourten, s_hour, s_minten, s_min, blank;
    logic [1:0] mode;
    logic       sec_tick, pm;

    int checks = 0;
    int fails  = 0;

    clock_set_ctrl #(.CLK_HZ(10), .DEB_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .s_hourten(s_hourten), .s_hour(s_hour), .s_minten(s_minten), .s_min(s_min),
        .blank(blank), .mode(mode), .sec_tick(sec_tick), .pm(pm)
    );

    always #5 clk = ~clk;

    task automatic press(input bit m, input bit i, input int hold);
        btn_mode = m;
        btn_inc  = i;
        repeat (hold) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < n * 12 + 20) begin
            if (sec_tick) got++;
            if (got < n) begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (got !== n) begin
            $display("FAIL tick_wait: saw %0d ticks, required %0d", got, n);
            fails++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({s_hourten, s_hour, s_minten, s_min} !== {RST_HT, RST_H, 8'h00}) begin
            $display("FAIL reset_digits: got %h, required %h", {s_hourten, s_hour, s_minten, s_min}, {RST_HT, RST_H, 8'h00});
            fails++;
        end
        checks++;
        if ({mode, blank, sec_tick, pm} !== 8'b0) begin
            $display("FAIL reset_ctrl: mode/blank/tick/pm got %b, required 0", {mode, blank, sec_tick, pm});
            fails++;
        end
    endtask

    task automatic test_set_hour;
        int ones = 0;
        int changes = 0;
        int bad = 0;
        logic [3:0] prev;
        press(1'b1, 1'b0, 8);
        checks++;
        if (mode !== 2'd1) begin
            $display("FAIL set_hour_mode: got %0d, required 1", mode);
            fails++;
        end
        repeat (3) press(1'b0, 1'b1, 8);
        checks++;
        if ({s_hourten, s_hour, s_minten, s_min, pm} !== {16'h0300, 1'b0}) begin
            $display("FAIL set_hour_time: got %h pm %b, required 0300 pm 0", {s_hourten, s_hour, s_minten, s_min}, pm);
            fails++;
        end
        prev = blank;
        for (int k = 0; k < 30; k++) begin
            if (blank == 4'b1100) ones++;
            else if (blank != 4'b0000) bad++;
            if (blank != prev) changes++;
            prev = blank;
            @(negedge clk);
        end
        checks++;
        if (ones !== 15 || bad !== 0 || changes < 5 || changes > 6) begin
            $display("FAIL set_hour_blink: ones %0d bad %0d changes %0d, required 15/0/5..6", ones, bad, changes);
            fails++;
        end
        checks++;
        if ({s_hourten, s_hour, s_minten, s_min} !== 16'h0300) begin
            $display("FAIL set_hour_hold: got %h, required 0300", {s_hourten, s_hour, s_minten, s_min});
            fails++;
        end
    endtask

    task automatic test_coincident;
        press(1'b1, 1'b1, 8);
        checks++;
        if (mode !== 2'd2 || {s_hourten, s_hour} !== 8'h03) begin
            $display("FAIL coincident: mode %0d hour %h, required mode 2 hour 03", mode, {s_hourten, s_hour});
            fails++;
        end
    endtask

    task automatic test_debounce;
        press(1'b0, 1'b1, 2);
        checks++;
        if ({s_minten, s_min} !== 8'h00) begin
            $display("FAIL glitch: minutes %h, required 00", {s_minten, s_min});
            fails++;
        end
        press(1'b0, 1'b1, 5);
        checks++;
        if ({s_hourten, s_hour, s_minten, s_min} !== 16'h0301) begin
            $display("FAIL min_inc: got %h, required 0301", {s_hourten, s_hour, s_minten, s_min});
            fails++;
        end
        press(1'b1, 1'b0, 8);
        checks++;
        if (mode !== 2'd0 || blank !== 4'b0000) begin
            $display("FAIL back_to_run: mode %0d blank %b, required 0/0000", mode, blank);
            fails++;
        end
    endtask

    task automatic test_reset_mid_set;
        press(1'b1, 1'b0, 8);
        press(1'b0, 1'b1, 8);
        checks++;
        if (mode !== 2'd1 || {s_hourten, s_hour} !== 8'h04) begin
            $display("FAIL mid_set_pre: mode %0d hour %h, required 1/04", mode, {s_hourten, s_hour});
            fails++;
        end
        rst = 1'b1;
        btn_inc = 1'b1;
        btn_mode = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        btn_inc = 1'b0;
        btn_mode = 1'b0;
        checks++;
        if ({mode, s_hourten, s_hour, s_minten, s_min, pm} !== {2'd0, RST_HT, RST_H, 8'h00, 1'b0}) begin
            $display("FAIL mid_set_reset: mode %0d time %h pm %b, required 0 %h 0", mode,
                     {s_hourten, s_hour, s_minten, s_min}, pm, {RST_HT, RST_H, 8'h00});
            fails++;
        end
    endtask

    task automatic test_rollover;
        int cyc = 0;
        wait_ticks(60);
        @(negedge clk);
        checks++;
        if ({s_hourten, s_hour, s_minten, s_min} !== {RST_HT, RST_H, 8'h01}) begin
            $display("FAIL run_60: got %h, required %h", {s_hourten, s_hour, s_minten, s_min}, {RST_HT, RST_H, 8'h01});
            fails++;
        end
        press(1'b1, 1'b0, 8);
        repeat (N_HR_INC) press(1'b0, 1'b1, 8);
        press(1'b1, 1'b0, 8);
        repeat (58) press(1'b0, 1'b1, 8);
        checks++;
        if ({mode, s_hourten, s_hour, s_minten, s_min} !== {2'd2, PRE_HT, PRE_H, 8'h59}) begin
            $display("FAIL set_pre: mode %0d time %h, required 2 %h", mode, {s_hourten, s_hour, s_minten, s_min}, {PRE_HT, PRE_H, 8'h59});
            fails++;
        end
        btn_mode = 1'b1;
        while (mode != 2'd0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        btn_mode = 1'b0;
        checks++;
        if (mode !== 2'd0) begin
            $display("FAIL return_run: mode %0d, required 0", mode);
            fails++;
        end
        wait_ticks(59);
        @(negedge clk);
        checks++;
        if ({s_hourten, s_hour, s_minten, s_min, pm} !== {PRE_HT, PRE_H, 8'h59, 1'b0}) begin
            $display("FAIL pre_wrap: got %h pm %b, required %h pm 0", {s_hourten, s_hour, s_minten, s_min}, pm, {PRE_HT, PRE_H, 8'h59});
            fails++;
        end
        wait_ticks(1);
        @(negedge clk);
        checks++;
        if ({s_hourten, s_hour, s_minten, s_min, pm} !== {END_HT, END_H, 8'h00, END_PM}) begin
            $display("FAIL wrap: got %h pm %b, required %h pm %b", {s_hourten, s_hour, s_minten, s_min}, pm,
                     {END_HT, END_H, 8'h00}, END_PM);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_set_hour();
        test_coincident();
        test_debounce();
        test_reset_mid_set();
        test_rollover();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 100000000, clk cycles per second.
REQ-002 SHALL provide parameter DEB_CYCLES, default 1000000, cycles a button must be stable to register (10 ms).
REQ-003 SHALL provide port clk  input  1  system clock; single clock domain.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port btn_mode  input  1  raw, asynchronous mode button.
REQ-006 SHALL provide port btn_inc  input  1  raw, asynchronous increment button.
REQ-007 SHALL provide ports s_hourten, s_hour, s_minten, s_min  output  4 each  BCD time digits for the display driver.
REQ-008 SHALL provide port blank  output  4  per-digit blank request, bit3=hourten ... bit0=min.
REQ-009 SHALL provide port mode  output  2  0=RUN, 1=SET_HR, 2=SET_MIN.
REQ-010 SHALL provide port sec_tick  output  1  one-cycle pulse per second.
REQ-011 SHALL provide port pm  output  1  PM flag.

Function
REQ-012 Prescaler SHALL count 0..CLK_HZ-1 and wrap; sec_tick SHALL be high exactly the cycle after the count equals CLK_HZ-1.
REQ-013 Each button SHALL pass a 2-flop synchronizer; the debounced level SHALL change only after DEB_CYCLES consecutive cycles of a differing synchronized value; a press SHALL be a one-cycle pulse on debounced 0->1.
REQ-014 In RUN, each tick SHALL increment internal seconds 0..59; 59 SHALL wrap to 0 and carry to minutes.
REQ-015 Minutes SHALL be BCD: s_min 9->0 carries s_minten; 59->00 carries hours.
REQ-016 Hours SHALL be BCD 00..23; 23:59:59 plus tick SHALL give 00:00:00.
REQ-017 FSM SHALL be RUN -> SET_HR -> SET_MIN -> RUN, advancing once per mode press; no other transitions.
REQ-018 In SET_HR/SET_MIN, ticks SHALL not advance time; seconds SHALL be cleared on SET_MIN->RUN.
REQ-019 An inc press in SET_HR SHALL add one hour, wrapping 23->00 without minute change; in SET_MIN it SHALL add one minute, wrapping 59->00 without hour carry; in RUN it SHALL be ignored.
REQ-020 Mode and inc presses in the same cycle: mode SHALL take effect, inc SHALL be dropped.
REQ-021 blink phase SHALL be 1 while prescaler < CLK_HZ/2; blank SHALL be 4'b0000 in RUN, {phase,phase,2'b00} in SET_HR, {2'b00,phase,phase} in SET_MIN.
REQ-022 All outputs SHALL be registered; digits SHALL reflect a tick or press one cycle after the event pulse.

Reset
REQ-023 rst SHALL set time 00:00:00, mode RUN, prescaler 0, sec_tick 0, blank 0, pm 0, debounced levels 0, synchronizers 0.
REQ-024 rst asserted mid-set SHALL abandon the edit and return to RUN with reset time; rst SHALL dominate all presses and ticks in the same cycle.

Configuration
REQ-025 Macro TWELVE_HOUR_EN defined: hours SHALL run 12,01..11 (BCD); 11->12 SHALL toggle pm in both RUN and SET_HR; 12->01 SHALL not toggle pm; reset time SHALL be 12:00:00, pm=0.
REQ-026 Macro TWELVE_HOUR_EN undefined: 24-hour behaviour per REQ-016; pm SHALL be constant 0.

Verification (CLK_HZ=10, DEB_CYCLES=3)
REQ-027 rst for 2 cycles -> digits 0,0,0,0, mode 0, blank 0000, sec_tick 0.
REQ-028 From 00:00:00 run 60 ticks -> 00:01; set 23:59 via buttons, return to RUN, 60 ticks -> 00:00.
REQ-029 One mode press then 3 inc presses -> mode 1, time 03:00, blank[3:2] alternating 11/00 every 5 cycles, no advance across 30 cycles.
REQ-030 btn_inc 2-cycle glitch in SET_MIN -> minutes unchanged; 5-cycle press -> minutes +1.
REQ-031 In SET_HR, mode and inc pulses coincident -> mode 2, hour unchanged.
REQ-032 With TWELVE_HOUR_EN: reset -> 12:00, pm 0; from 11:59:59 one tick -> 12:00:00, pm 1.
